// File: rtl/arith_unit_pkg.sv
// Shared op codes and width helper for the arithmetic_unit ALU slice.
package arith_unit_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_INV = 2'b11
  } op_e;

  // Result is double width so a full product never truncates.
  function automatic int result_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/arith_unit_mul.sv
// Combinational WIDTH x WIDTH -> 2*WIDTH unsigned multiplier, kept separate for a later DSP/pipelined swap.
module arith_unit_mul
  import arith_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]                i_a,
  input  logic [WIDTH-1:0]                i_b,
  output logic [result_width(WIDTH)-1:0]  o_prod
);

  logic [result_width(WIDTH)-1:0] w_a_ext;
  logic [result_width(WIDTH)-1:0] w_b_ext;

  assign w_a_ext = {{WIDTH{1'b0}}, i_a};
  assign w_b_ext = {{WIDTH{1'b0}}, i_b};
  assign o_prod  = w_a_ext * w_b_ext;

endmodule

// File: rtl/arithmetic_unit.sv
// Registered add/sub/mul ALU slice, 1-cycle latency, 2*WIDTH result.
// Define ARITH_UNIT_ERR_EN to add the err output flagging invalid op codes.
module arithmetic_unit
  import arith_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  input  logic [1:0]                      op,
  output logic                            out_valid,
`ifdef ARITH_UNIT_ERR_EN
  output logic [result_width(WIDTH)-1:0]  result,
  output logic                            err
`else
  output logic [result_width(WIDTH)-1:0]  result
`endif
);

  localparam int RW = result_width(WIDTH);

  logic [RW-1:0] w_a_ext;
  logic [RW-1:0] w_b_ext;
  logic [RW-1:0] w_sum;
  logic [RW-1:0] w_diff;
  logic [RW-1:0] w_prod;
  logic [RW-1:0] w_next;
  op_e           w_op;

  logic [RW-1:0] r_result;
  logic          r_valid;

  assign w_op    = op_e'(op);
  assign w_a_ext = {{WIDTH{1'b0}}, a};
  assign w_b_ext = {{WIDTH{1'b0}}, b};
  // Modulo 2^RW arithmetic: a borrow on sub fills the upper bits with ones.
  assign w_sum   = w_a_ext + w_b_ext;
  assign w_diff  = w_a_ext - w_b_ext;

  arith_unit_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_a    (a),
    .i_b    (b),
    .o_prod (w_prod)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = '0;
    case (w_op)
      OP_ADD:  w_next = w_sum;
      OP_SUB:  w_next = w_diff;
      OP_MUL:  w_next = w_prod;
      OP_INV:  w_next = '0;
      default: w_next = '0;
    endcase
  end

  // NOTE: non-blocking assignments in clocked blocks so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_next;
      end
    end
  end

  assign result    = r_result;
  assign out_valid = r_valid;

`ifdef ARITH_UNIT_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (in_valid) begin
      r_err <= (w_op == OP_INV);
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_arithmetic_unit.sv
// Directed self-checking bench for arithmetic_unit (WIDTH=8); honours ARITH_UNIT_ERR_EN.
module tb_arithmetic_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  op;
  logic        out_valid;
  logic [15:0] result;
`ifdef ARITH_UNIT_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  arithmetic_unit #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
`ifdef ARITH_UNIT_ERR_EN
    .result    (result),
    .err       (err)
`else
    .result    (result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one op at the falling edge, then sample just after the capturing rising edge.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top);
    @(negedge clk);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    op       = top;
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string tag, input logic [15:0] exp, input logic exp_err);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp});
`ifdef ARITH_UNIT_ERR_EN
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
`else
    if (exp_err) checks += 0;
`endif
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;

    #2;
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
`ifdef ARITH_UNIT_ERR_EN
    check("reset_err", {31'd0, err}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    do_op(8'h0F, 8'h01, 2'b00); check_op("add",     16'h0010, 1'b0);
    do_op(8'h0F, 8'h01, 2'b01); check_op("sub",     16'h000E, 1'b0);
    do_op(8'h01, 8'h02, 2'b01); check_op("borrow",  16'hFFFF, 1'b0);
    do_op(8'h03, 8'h02, 2'b10); check_op("mul",     16'h0006, 1'b0);
    do_op(8'hFF, 8'hFF, 2'b10); check_op("mul_max", 16'hFE01, 1'b0);
    do_op(8'hFF, 8'hFF, 2'b00); check_op("carry",   16'h01FE, 1'b0);
    do_op(8'h0F, 8'h01, 2'b11); check_op("invalid", 16'h0000, 1'b1);
    do_op(8'h03, 8'h02, 2'b10); check_op("post_inv", 16'h0006, 1'b0);

    // Idle cycles with random operands must not disturb the held result.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      op       = 2'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd0);
      check("hold_result", {16'd0, result}, 32'h0006);
`ifdef ARITH_UNIT_ERR_EN
      check("hold_err", {31'd0, err}, 32'd0);
`endif
    end

    // Four back-to-back ops: in_valid never drops between them.
    do_op(8'h10, 8'h20, 2'b00); check_op("b2b0", 16'h0030, 1'b0);
    do_op(8'h50, 8'h60, 2'b01); check_op("b2b1", 16'hFFF0, 1'b0);
    do_op(8'h10, 8'h10, 2'b10); check_op("b2b2", 16'h0100, 1'b0);
    do_op(8'h80, 8'h7F, 2'b00); check_op("b2b3", 16'h00FF, 1'b0);

    // Asynchronous reset between edges clears outputs immediately.
    do_op(8'h01, 8'h01, 2'b00); check_op("pre_rst", 16'h0002, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_result", {16'd0, result}, 32'd0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_result", {16'd0, result}, 32'd0);

    do_op(8'h02, 8'h03, 2'b00); check_op("resume", 16'h0005, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
